pc_uart_rx: RTL and testbench

- Serial front end for the PC command path. Receives 8N1 UART frames from the host PC and buffers the received bytes in a small FIFO.
- Presents the bytes as a valid/ready byte stream (pc_cmd_valid / pc_cmd_data) to the test-system command input.
- Sits directly upstream of the test-system top-level command port. Flags framing errors and FIFO overflow to status logic.

---
 rtl/pc_uart_rx.sv | 202 ++++++++++++++++++++
 tb/tb_pc_uart_rx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_uart_rx.sv
// pc_uart_rx: oversampled UART receiver feeding a valid/ready byte FIFO.
// Define PC_UART_RX_PARITY_EN to expect an even-parity bit after D7.
module pc_uart_rx #(
   parameter int CLK_HZ      = 100000000,
   parameter int BAUD        = 115200,
   parameter int OVERSAMPLE  = 16,
   parameter int FIFO_DEPTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          uart_rx,
   input  logic                          pc_cmd_ready,
   output logic                          pc_cmd_valid,
   output logic [7:0]                    pc_cmd_data,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          framing_err,
   output logic                          overflow,
`ifdef PC_UART_RX_PARITY_EN
   output logic                          parity_err,
`endif
   output logic                          rx_busy
);

   localparam int DIV  = CLK_HZ / (BAUD * OVERSAMPLE);
   localparam int TW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int SW   = $clog2(OVERSAMPLE);
   localparam int HALF = OVERSAMPLE / 2;
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int LW   = AW + 1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef PC_UART_RX_PARITY_EN
      PARITY,
`endif
      STOP,
      BREAK
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rx_s, rx_prev, rx_fall;
   logic [TW-1:0]          tick_cnt;
   logic                   tick;
   logic [SW-1:0]          smp_cnt;
   logic [2:0]             bit_cnt;
   logic [1:0]             hist;
   logic                   vote;
   logic [7:0]             shreg;
   logic                   at_mid, at_late, at_end;
   logic                   smp_clr, bit_inc, shift_en;
   logic                   byte_wr, ferr_d, par_bad;

   assign rx_s    = sync_q[SYNC_STAGES-1];
   assign rx_fall = rx_prev & ~rx_s;
   assign tick    = (tick_cnt == TW'(DIV - 1));
   // hist holds the two previous tick samples; rx_s is the current one
   assign vote    = (hist[1] & hist[0]) | (hist[1] & rx_s)
                  | (hist[0] & rx_s);
   assign at_mid  = tick && (smp_cnt == SW'(HALF));
   assign at_late = tick && (smp_cnt == SW'(HALF + 1));
   assign at_end  = tick && (smp_cnt == SW'(OVERSAMPLE - 1));
   assign rx_busy = (state_q != IDLE);

`ifdef PC_UART_RX_PARITY_EN
   logic perr_d;
   localparam state_t AFTER_DATA = PARITY;
`else
   localparam state_t AFTER_DATA = STOP;
   assign par_bad = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      smp_clr  = 1'b0;
      bit_inc  = 1'b0;
      shift_en = 1'b0;
      byte_wr  = 1'b0;
      ferr_d   = 1'b0;
`ifdef PC_UART_RX_PARITY_EN
      perr_d   = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (rx_fall) begin
               state_d = START;
               smp_clr = 1'b1;
            end
         end
         START: begin
            if (at_mid) begin
               smp_clr = 1'b1;
               state_d = vote ? IDLE : DATA;
            end
         end
         DATA: begin
            shift_en = at_late;
            if (at_end) begin
               smp_clr = 1'b1;
               bit_inc = 1'b1;
               if (bit_cnt == 3'd7) state_d = AFTER_DATA;
            end
         end
`ifdef PC_UART_RX_PARITY_EN
         PARITY: begin
            perr_d = at_late && (vote != ^shreg);
            if (at_end) begin
               smp_clr = 1'b1;
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            if (at_late) begin
               if (vote) begin
                  byte_wr = ~par_bad;
                  state_d = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = BREAK;
               end
            end
         end
         BREAK: begin
            if (rx_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q      <= '1;
         rx_prev     <= 1'b1;
         state_q     <= IDLE;
         tick_cnt    <= '0;
         smp_cnt     <= '0;
         bit_cnt     <= '0;
         hist        <= '1;
         shreg       <= '0;
         framing_err <= 1'b0;
      end else begin
         sync_q      <= {sync_q[SYNC_STAGES-2:0], uart_rx};
         rx_prev     <= rx_s;
         state_q     <= state_d;
         framing_err <= ferr_d;
         if (state_q == IDLE || tick) tick_cnt <= '0;
         else tick_cnt <= tick_cnt + 1'b1;
         if (tick) hist <= {hist[0], rx_s};
         if (smp_clr) smp_cnt <= '0;
         else if (tick) smp_cnt <= smp_cnt + 1'b1;
         if (state_q == IDLE) bit_cnt <= '0;
         else if (bit_inc) bit_cnt <= bit_cnt + 1'b1;
         if (shift_en) shreg <= {vote, shreg[7:1]};
      end
   end

`ifdef PC_UART_RX_PARITY_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         par_bad    <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         parity_err <= perr_d;
         if (state_q == IDLE) par_bad <= 1'b0;
         else if (perr_d) par_bad <= 1'b1;
      end
   end
`endif

   logic [7:0]  mem [FIFO_DEPTH];
   logic [AW:0] wptr, rptr;
   logic        full, pop, wr_ok;

   assign fifo_level   = wptr - rptr;
   assign full         = (fifo_level == LW'(FIFO_DEPTH));
   assign pc_cmd_valid = (fifo_level != '0);
   assign pc_cmd_data  = mem[rptr[AW-1:0]];
   assign pop          = pc_cmd_valid && pc_cmd_ready;
   // a same-cycle pop frees the slot, so a full FIFO can still take the byte
   assign wr_ok        = byte_wr && (!full || pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr     <= '0;
         rptr     <= '0;
         overflow <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         overflow <= byte_wr && full && !pop;
         if (wr_ok) begin
            mem[wptr[AW-1:0]] <= shreg;
            wptr              <= wptr + 1'b1;
         end
         if (pop) rptr <= rptr + 1'b1;
      end
   end

endmodule

// File: tb/tb_pc_uart_rx.sv
// tb_pc_uart_rx: scoreboard bench for the PC command UART receiver.
// Clock is chosen so 115200 baud divides exactly (DIV = 6).
module tb_pc_uart_rx;

   localparam int CLK_HZ = 11059200;
   localparam int BAUD   = 115200;
   localparam int OS     = 16;
   localparam int DIV    = CLK_HZ / (BAUD * OS);
   localparam int BIT    = DIV * OS;
`ifdef PC_UART_RX_PARITY_EN
   localparam int NB     = 9;
`else
   localparam int NB     = 8;
`endif
   // ticks from start detect to the stop-bit vote, plus two sync cycles
   localparam int STOP_TICK = (OS/2 + 1) + NB*OS + (OS/2 + 2);
   localparam int STOP_CYC  = 2 + DIV*STOP_TICK;

   logic       clk = 1'b0;
   logic       rst;
   logic       uart_rx;
   logic       pc_cmd_ready;
   logic       pc_cmd_valid;
   logic [7:0] pc_cmd_data;
   logic [3:0] fifo_level;
   logic       framing_err;
   logic       overflow;
   logic       rx_busy;
`ifdef PC_UART_RX_PARITY_EN
   logic       parity_err;
   logic       par_flip = 1'b0;
   int         perr_n = 0;
`endif

   int total = 0;
   int bad   = 0;
   int vld_cyc = 0;
   int ferr_n  = 0;
   int ovf_n   = 0;
   int v0, o0;
   logic [7:0] exp_q [$];

   pc_uart_rx #(
      .CLK_HZ(CLK_HZ),
      .BAUD  (BAUD)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .uart_rx     (uart_rx),
      .pc_cmd_ready(pc_cmd_ready),
      .pc_cmd_valid(pc_cmd_valid),
      .pc_cmd_data (pc_cmd_data),
      .fifo_level  (fifo_level),
      .framing_err (framing_err),
      .overflow    (overflow),
`ifdef PC_UART_RX_PARITY_EN
      .parity_err  (parity_err),
`endif
      .rx_busy     (rx_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input logic stop_v);
      uart_rx = 1'b0;
      step(BIT);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         step(BIT);
      end
`ifdef PC_UART_RX_PARITY_EN
      uart_rx = (^b) ^ par_flip;
      step(BIT);
`endif
      uart_rx = stop_v;
      step(BIT);
      uart_rx = 1'b1;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (pc_cmd_valid) vld_cyc++;
         if (framing_err) ferr_n++;
         if (overflow) ovf_n++;
`ifdef PC_UART_RX_PARITY_EN
         if (parity_err) perr_n++;
`endif
         if (pc_cmd_valid && pc_cmd_ready) begin
            if (exp_q.size() == 0) check("extra_byte", {24'h0, pc_cmd_data}, 32'h100);
            else check("byte", {24'h0, pc_cmd_data}, {24'h0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      #(60000 * 10);
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      uart_rx      = 1'b1;
      pc_cmd_ready = 1'b0;
      rst          = 1'b1;
      step(3);
      check("rst_valid", pc_cmd_valid, 0);
      check("rst_data", pc_cmd_data, 0);
      check("rst_level", fifo_level, 0);
      check("rst_ferr", framing_err, 0);
      check("rst_ovf", overflow, 0);
      check("rst_busy", rx_busy, 0);
      rst = 1'b0;
      step(5);

      pc_cmd_ready = 1'b1;
      v0 = vld_cyc;
      exp_q.push_back(8'hA5);
      send(8'hA5, 1'b1);
      step(2*BIT);
      check("a5_vld_cycles", vld_cyc - v0, 1);
      check("a5_ferr", ferr_n, 0);
      check("a5_ovf", ovf_n, 0);
      check("a5_sb", exp_q.size(), 0);

      v0 = vld_cyc;
      uart_rx = 1'b0;
      step(BIT/4);
      uart_rx = 1'b1;
      step(4);
      check("gl_busy_hi", rx_busy, 1);
      step(DIV*(OS/2 + 1));
      check("gl_busy_lo", rx_busy, 0);
      step(BIT);
      check("gl_vld", vld_cyc - v0, 0);
      check("gl_ferr", ferr_n, 0);

      send(8'h3C, 1'b0);
      check("fe_busy_hi", rx_busy, 1);
      step(4);
      check("fe_busy_lo", rx_busy, 0);
      check("fe_cnt", ferr_n, 1);
      check("fe_level", fifo_level, 0);
      step(BIT);
      exp_q.push_back(8'h5A);
      send(8'h5A, 1'b1);
      step(2*BIT);
      check("fe_next_sb", exp_q.size(), 0);

      pc_cmd_ready = 1'b0;
      o0 = ovf_n;
      for (int i = 0; i < 9; i++) begin
         if (i < 8) exp_q.push_back(8'(i));
         send(8'(i), 1'b1);
         step(BIT/2);
         if (i == 7) check("ov_none_at_8", ovf_n - o0, 0);
      end
      check("ov_level", fifo_level, 8);
      check("ov_cnt", ovf_n - o0, 1);
      check("ov_head", pc_cmd_data, 8'h00);
      pc_cmd_ready = 1'b1;
      step(12);
      check("ov_drained", fifo_level, 0);
      check("ov_sb", exp_q.size(), 0);

      pc_cmd_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(8'(8'h10 + i));
         send(8'(8'h10 + i), 1'b1);
         step(BIT/2);
      end
      check("fp_full", fifo_level, 8);
      o0 = ovf_n;
      exp_q.push_back(8'h77);
      fork
         send(8'h77, 1'b1);
         begin
            step(STOP_CYC);
            pc_cmd_ready = 1'b1;
            step(1);
            pc_cmd_ready = 1'b0;
         end
      join
      step(BIT);
      check("fp_ovf", ovf_n - o0, 0);
      check("fp_level", fifo_level, 8);
      check("fp_sb_left", exp_q.size(), 8);
      pc_cmd_ready = 1'b1;
      step(12);
      check("fp_drained", fifo_level, 0);
      check("fp_sb", exp_q.size(), 0);

      v0 = vld_cyc;
      fork
         send(8'hFF, 1'b1);
         begin
            step(3*BIT);
            rst = 1'b1;
            step(2);
            check("mr_valid", pc_cmd_valid, 0);
            check("mr_data", pc_cmd_data, 0);
            check("mr_level", fifo_level, 0);
            check("mr_busy", rx_busy, 0);
            check("mr_ferr", framing_err, 0);
            check("mr_ovf", overflow, 0);
            step(3);
            rst = 1'b0;
         end
      join
      step(BIT);
      exp_q.push_back(8'h81);
      send(8'h81, 1'b1);
      step(2*BIT);
      check("mr_vld_cycles", vld_cyc - v0, 1);
      check("mr_sb", exp_q.size(), 0);

`ifdef PC_UART_RX_PARITY_EN
      v0 = vld_cyc;
      o0 = perr_n;
      par_flip = 1'b1;
      send(8'h81, 1'b1);
      par_flip = 1'b0;
      step(2*BIT);
      check("par_err", perr_n - o0, 1);
      check("par_vld", vld_cyc - v0, 0);
      check("par_level", fifo_level, 0);
`endif

      check("sb_final", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
